// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single UART register port.
// Master 0 is the CPU, master 1 a host/tester. A transaction stuck without
// s_ready for TIMEOUT cycles is aborted and answered with all-ones data.
module uart_bus_arbiter #(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  output logic [1:0]          grant,
  output logic                timeout
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;

  logic owner_valid;
  logic timeout_fire;

  // Owner still requesting, and the abort condition for the current cycle
  always_comb begin
    owner_valid  = ((state_q == GNT0) && m0_valid) || ((state_q == GNT1) && m1_valid);
    timeout_fire = owner_valid && !s_ready && (cnt_q == TIMEOUT_CNT);
  end

  // Next-state, round-robin pointer (1 = m1 wins next tie) and wait counter
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (m0_valid && m1_valid) begin
          state_d = ptr_q ? GNT1 : GNT0;
        end else if (m0_valid) begin
          state_d = GNT0;
        end else if (m1_valid) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!owner_valid) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else if (s_ready || timeout_fire) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          ptr_d   = (state_q == GNT0);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    grant_d = {state_d == GNT1, state_d == GNT0};
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= 16'd0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  // Route the owning master to the UART and the UART response back
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    case (state_q)
      GNT0: begin
        s_valid  = m0_valid && !timeout_fire;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready || timeout_fire;
        m0_rdata = timeout_fire ? {DATA_W{1'b1}} : s_rdata;
      end
      GNT1: begin
        s_valid  = m1_valid && !timeout_fire;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready || timeout_fire;
        m1_rdata = timeout_fire ? {DATA_W{1'b1}} : s_rdata;
      end
      default: begin
        s_valid = 1'b0;
      end
    endcase
  end

  assign grant   = grant_q;
  assign timeout = timeout_fire;

endmodule

// File: doc/uart_bus_arbiter.md
UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, UART register address width.
REQ-002 SHALL have parameter DATA_W, default 32, data bus width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles a grant waits for s_ready (1..65535).
REQ-004 SHALL have ports, one per line:
clk  in  1  single clock, all logic on rising edge.
rst  in  1  synchronous, active-low reset.
m0_valid  in  1  master 0 (CPU) request.
m0_addr  in  ADDR_W  master 0 address.
m0_wdata  in  DATA_W  master 0 write data.
m0_wstrb  in  DATA_W/8  master 0 byte strobes (0 = read).
m0_rdata  out  DATA_W  master 0 read data.
m0_ready  out  1  master 0 completion.
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready  as master 0, for master 1 (host/tester).
s_valid  out  1  request to UART.
s_addr  out  ADDR_W  UART address.
s_wdata  out  DATA_W  UART write data.
s_wstrb  out  DATA_W/8  UART strobes.
s_rdata  in  DATA_W  UART read data.
s_ready  in  1  UART completion.
grant  out  2  one-hot current owner (bit0 = m0), 0 when idle.
timeout  out  1  one-cycle pulse on aborted transaction.

Function
REQ-005 SHALL implement FSM states IDLE, GNT0, GNT1; reset state IDLE.
REQ-006 In IDLE with exactly one mN_valid high, SHALL enter GNTN next edge.
REQ-007 In IDLE with both valid, SHALL grant the master not granted last (round-robin pointer); after reset pointer favours m0.
REQ-008 Arbitration latency SHALL be one cycle: valid at edge k, s_valid high from edge k+1.
REQ-009 In GNTN, s_valid/s_addr/s_wdata/s_wstrb SHALL combinationally follow master N; mN_ready = s_ready; mN_rdata = s_rdata.
REQ-010 Non-granted master SHALL see ready=0 and rdata=0; in IDLE s_valid=0, s_addr/s_wdata/s_wstrb=0.
REQ-011 On s_valid && s_ready in GNTN, SHALL return to IDLE next edge and set pointer so the other master wins the next tie.
REQ-012 Back-to-back: a master keeping valid high after completion SHALL re-arbitrate in IDLE (one idle cycle minimum between transactions).
REQ-013 If mN_valid drops in GNTN before s_ready, SHALL return to IDLE next edge without pointer update and without timeout.
REQ-014 SHALL count cycles in GNTN with s_ready low using a 16-bit counter cleared on grant entry.
REQ-015 When the counter reaches TIMEOUT with s_ready still low, SHALL in that cycle drive mN_ready=1, mN_rdata all-ones, s_valid=0, timeout=1, then go to IDLE with pointer updated.
REQ-016 s_ready arriving in the same cycle as count==TIMEOUT SHALL be treated as normal completion, timeout=0.
REQ-017 s_ready while IDLE SHALL be ignored.
REQ-018 grant SHALL be registered, equal to one-hot FSM state.

Reset
REQ-019 rst low at any edge, including mid-transaction, SHALL force IDLE, grant=0, timeout=0, counter=0, pointer=m0, all outputs 0 next cycle; pending transaction is dropped.

Verification
REQ-020 m0 read addr 2, UART ready after 3 cycles, rdata 0x55 -> grant=01 one cycle after valid, m0_ready with rdata 0x55, m1_ready 0.
REQ-021 m0 and m1 valid together from reset, UART ready after 1 cycle each -> m0 served first, then m1, then m0; grant 01,00,10,00,01.
REQ-022 TIMEOUT=4, m1 write, s_ready never asserted -> after 4 waiting cycles m1_ready=1, m1_rdata=0xFFFFFFFF, timeout pulse 1 cycle, grant=00.
REQ-023 TIMEOUT=4, s_ready on exact timeout cycle -> normal completion, timeout stays 0.
REQ-024 m0 granted, rst low for one cycle before s_ready -> grant=00, s_valid=0 next cycle; subsequent m1 request granted normally.
REQ-025 m1 drops valid in GNT1 before ready -> IDLE next edge, no timeout, next tie still favours m1's pointer state unchanged.
